dac_dma_rd: RTL and testbench
=============================

Name: dac_dma_rd

Overview:
- Bus-master read DMA that streams DAC waveform samples from memory (DMEM or SDRAM via soc_fabric) to the DAC interface.
- Counterpart of the ADC write-DMA:
  - Fetches 32-bit words, each holding one CH1/CH2 10-bit sample pair.
  - Buffers the words in a small FIFO.
  - Releases one pair per strobe_27 to dac.
- Configured and monitored through csr (DAC DMA registers).

Parameters:
- FIFO_DEPTH, 8, FIFO depth in 32-bit words; power of 2, minimum 4.
- LEN_W, 16, width of the transfer-length field in words.

Ports:
- clk  in  1  system clock (clk_54 domain)
- arst  in  1  asynchronous reset, active-high
- cfg_en  in  1  DMA enable; rising edge starts a transfer, low aborts it
- cfg_loop  in  1  1 = restart from cfg_base after the last word
- cfg_base  in  30  word address of the first word, [31:2]
- cfg_len  in  LEN_W  number of words to read
- strobe  in  1  sample-rate pulse (strobe_27), one clk wide
- bus_req  out  1  read request
- bus_addr  out  30  read word address [31:2]
- bus_gnt  in  1  request accepted when bus_req & bus_gnt
- bus_rvld  in  1  read data valid
- bus_rdat  in  32  read data
- dac_ch1  out  10  CH1 sample, taken from word[9:0]
- dac_ch2  out  10  CH2 sample, taken from word[25:16]
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at end of a non-loop transfer
- underrun  out  1  sticky flag; cleared by the next cfg_en rising edge
- underrun_cnt  out  16  underrun count; only when the optional feature is compiled in

Behaviour:
- Reset values: bus_req=0, bus_addr=0, dac_ch1=dac_ch2=10'h200 (mid-scale), busy=0, done=0, underrun=0, underrun_cnt=0, FIFO empty.
- Fetch FSM states:
  - IDLE: on cfg_en rising edge with cfg_len!=0, latch base and len, set busy, go to REQ. With cfg_len==0, pulse done the next cycle, make no bus access, stay in IDLE.
  - REQ: assert bus_req only when FIFO free slots ≥1 (the in-flight read is counted). Hold bus_req and bus_addr stable until bus_gnt, then go to WAIT.
  - WAIT: on bus_rvld, push bus_rdat into the FIFO and increment the index.
    - Index below len: go to REQ.
    - Last word with cfg_loop=1: index becomes 0, go to REQ.
    - Last word with cfg_loop=0: go to DRAIN.
  - DRAIN: when the FIFO is empty and the last pair has been output, pulse done, clear busy, go to IDLE.
- At most one read is outstanding at a time.
- bus_addr = cfg_base + index, wrapping modulo 2^30.
- Abort:
  - cfg_en low in REQ before the grant: drop bus_req immediately.
  - cfg_en low in WAIT: wait for bus_rvld and discard the data. A read is never abandoned.
  - In both cases, flush the FIFO, clear busy, go to IDLE; no done pulse.
- Output side:
  - When strobe and busy and the FIFO is non-empty: pop one word; dac_ch1/dac_ch2 update on the next clk edge (1-cycle latency).
  - strobe with busy and the FIFO empty: underrun. Hold the previous outputs, set underrun, increment underrun_cnt.
  - No underrun is counted in DRAIN once the FIFO is empty.
  - Outputs hold their last value after done or an abort.
- Push and pop in the same cycle on a full or empty FIFO are both legal; occupancy is unchanged.
- cfg_base, cfg_len and cfg_loop are sampled only at start. Changes made mid-transfer are ignored until the next start.

Optional Feature:
- DAC_DMA_UNDERRUN_CNT_EN defined: underrun_cnt is a 16-bit saturating counter (sticks at 16'hFFFF), cleared at start.
- Undefined: underrun_cnt is tied to 0 and the counter logic is absent; the sticky underrun flag remains.

Decomposition:
- soc_pkg holds:
  - dac_pair_t (packed ch2/ch1 10-bit fields at the word bit positions above).
  - DAC_MIDSCALE = 10'h200.
  - the fetch FSM state enum.
- Sub-module soc_fifo_sync (parameterised WIDTH/DEPTH).
  - Ports: push, pop, full, empty, free count.
  - Reusable by the ADC DMA.

Test Plan:
- base=0x100, len=4, loop=0, zero-wait bus, strobe every 2 cycles:
  - 4 reads to 0x100..0x103.
  - Pairs appear in order, 1 cycle after each strobe.
  - done pulses once, busy falls, underrun=0.
- len=0 -> done pulses 1 cycle after cfg_en rises; bus_req never asserted.
- loop=1, len=3 -> addresses 0x100,0x101,0x102,0x100,...; busy stays 1; no done.
- bus_rvld delayed 20 cycles with strobe every cycle:
  - underrun sets and dac outputs hold.
  - With DAC_DMA_UNDERRUN_CNT_EN, underrun_cnt equals the missed strobes.
- Drop cfg_en while in WAIT:
  - bus_req stays low after the pending bus_rvld; that data is not output.
  - FIFO empty, busy=0, no done.
- Stall strobe with len=20 and FIFO_DEPTH=8:
  - exactly 8 words are fetched, then bus_req stays low.
  - One strobe -> exactly one further read.

Source files
------------

// File: rtl/soc_pkg.sv
// Shared types for the DAC read-DMA: sample-pair word layout,
// mid-scale constant and fetch FSM states.
package soc_pkg;

    localparam logic [9:0] DAC_MIDSCALE = 10'h200;

    typedef struct packed {
        logic [5:0] pad_hi;
        logic [9:0] ch2;
        logic [5:0] pad_lo;
        logic [9:0] ch1;
    } dac_pair_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_DRAIN,
        ST_ABORT
    } fetch_st_t;

endpackage

// File: rtl/soc_fifo_sync.sv
// Single-clock FIFO with show-ahead read, synchronous flush and free count.
// Push+pop on full or empty keeps occupancy (empty case passes data through).
module soc_fifo_sync #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CAP = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [AW:0]      r_cnt;
    logic             w_byp;
    logic             w_wr;
    logic             w_rd;

    assign empty = (r_cnt == '0);
    assign full  = (r_cnt == CAP);
    assign free  = CAP - r_cnt;
    assign w_byp = push & pop & empty;
    assign w_wr  = push & (~full | pop) & ~w_byp;
    assign w_rd  = pop & ~empty;
    assign dout  = empty ? din : r_mem[r_rp];

    // storage write port
    always_ff @(posedge clk) begin
        if (w_wr && !flush)
            r_mem[r_wp] <= din;
    end

    // pointers and occupancy
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + AW'(1);
            if (w_rd)
                r_rp <= r_rp + AW'(1);
            if (w_wr && !w_rd)
                r_cnt <= r_cnt + (AW+1)'(1);
            else if (!w_wr && w_rd)
                r_cnt <= r_cnt - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/dac_dma_rd.sv
// Read DMA streaming CH1/CH2 sample pairs from the bus to the DAC.
// Optional: define DAC_DMA_UNDERRUN_CNT_EN for the saturating underrun counter.
module dac_dma_rd
    import soc_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             arst,
    input  logic             cfg_en,
    input  logic             cfg_loop,
    input  logic [29:0]      cfg_base,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic             strobe,
    output logic             bus_req,
    output logic [29:0]      bus_addr,
    input  logic             bus_gnt,
    input  logic             bus_rvld,
    input  logic [31:0]      bus_rdat,
    output logic [9:0]       dac_ch1,
    output logic [9:0]       dac_ch2,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic [15:0]      underrun_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);

    fetch_st_t        r_st;
    fetch_st_t        w_nxt;
    logic             r_en_d;
    logic [29:0]      r_base;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_idx;
    logic             r_loop;
    logic             r_busy;
    logic             r_done;
    logic             r_und;
    logic [9:0]       r_ch1;
    logic [9:0]       r_ch2;

    logic [LEN_W-1:0] w_idx_nx;
    logic             w_last;
    logic             w_go;
    logic             w_req;
    logic             w_push;
    logic             w_flush;
    logic             w_fin;
    logic             w_pop;
    logic             w_und;
    logic [31:0]      w_dout;
    logic             w_full;
    logic             w_empty;
    logic [AW:0]      w_free;
    dac_pair_t        w_pair;
    logic             w_unused;

    assign w_idx_nx = r_idx + LEN_W'(1);
    assign w_last   = (w_idx_nx == r_len);
    assign w_go     = (r_st == ST_IDLE) & cfg_en & ~r_en_d;
    assign w_pop    = strobe & r_busy & cfg_en & ~w_empty;
    assign w_und    = strobe & r_busy & cfg_en & w_empty & (r_st != ST_DRAIN);
    assign w_pair   = dac_pair_t'(w_dout);
    assign w_unused = ^{w_pair.pad_hi, w_pair.pad_lo, w_full};

    assign bus_req  = w_req;
    assign bus_addr = r_base + 30'(r_idx);
    assign dac_ch1  = r_ch1;
    assign dac_ch2  = r_ch2;
    assign busy     = r_busy;
    assign done     = r_done;
    assign underrun = r_und;

    soc_fifo_sync #(
        .WIDTH (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .arst  (arst),
        .flush (w_flush),
        .push  (w_push),
        .din   (bus_rdat),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .free  (w_free)
    );

    // fetch state register
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_st <= ST_IDLE;
        else
            r_st <= w_nxt;
    end

    // fetch next-state; an issued read is always completed before idling
    always_comb begin
        w_nxt = r_st;
        unique case (r_st)
            ST_IDLE: begin
                if (w_go && cfg_len != '0)
                    w_nxt = ST_REQ;
            end
            ST_REQ: begin
                if (!cfg_en)
                    w_nxt = ST_IDLE;
                else if (w_req && bus_gnt)
                    w_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (bus_rvld) begin
                    if (!cfg_en)
                        w_nxt = ST_IDLE;
                    else if (!w_last || r_loop)
                        w_nxt = ST_REQ;
                    else
                        w_nxt = ST_DRAIN;
                end else if (!cfg_en) begin
                    w_nxt = ST_ABORT;
                end
            end
            ST_DRAIN: begin
                if (!cfg_en || w_empty)
                    w_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                if (bus_rvld)
                    w_nxt = ST_IDLE;
            end
            default: w_nxt = ST_IDLE;
        endcase
    end

    // fetch outputs; request only with a free slot for the returning word
    always_comb begin
        w_req   = 1'b0;
        w_push  = 1'b0;
        w_flush = 1'b0;
        w_fin   = 1'b0;
        unique case (r_st)
            ST_REQ: begin
                w_req   = cfg_en & (w_free != '0);
                w_flush = ~cfg_en;
            end
            ST_WAIT: begin
                w_push  = cfg_en & bus_rvld;
                w_flush = ~cfg_en;
            end
            ST_DRAIN: begin
                w_fin   = cfg_en & w_empty;
                w_flush = ~cfg_en;
            end
            default: ;
        endcase
    end

    // transfer context, busy/done and sticky underrun
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_en_d <= 1'b0;
            r_base <= '0;
            r_len  <= '0;
            r_idx  <= '0;
            r_loop <= 1'b0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_und  <= 1'b0;
        end else begin
            r_en_d <= cfg_en;
            r_done <= 1'b0;
            if (w_go) begin
                r_base <= cfg_base;
                r_len  <= cfg_len;
                r_loop <= cfg_loop;
                r_idx  <= '0;
                r_busy <= (cfg_len != '0);
                r_done <= (cfg_len == '0);
                r_und  <= 1'b0;
            end
            if (w_push)
                r_idx <= (w_last && r_loop) ? '0 : w_idx_nx;
            if (w_fin) begin
                r_done <= 1'b1;
                r_busy <= 1'b0;
            end
            if (w_flush)
                r_busy <= 1'b0;
            if (w_und)
                r_und <= 1'b1;
        end
    end

    // DAC sample registers, updated on each successful pop
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            r_ch1 <= DAC_MIDSCALE;
            r_ch2 <= DAC_MIDSCALE;
        end else if (w_pop) begin
            r_ch1 <= w_pair.ch1;
            r_ch2 <= w_pair.ch2;
        end
    end

`ifdef DAC_DMA_UNDERRUN_CNT_EN
    logic [15:0] r_und_cnt;

    // saturating underrun counter, cleared at start
    always_ff @(posedge clk or posedge arst) begin
        if (arst)
            r_und_cnt <= '0;
        else if (w_go)
            r_und_cnt <= '0;
        else if (w_und && r_und_cnt != 16'hFFFF)
            r_und_cnt <= r_und_cnt + 16'd1;
    end

    assign underrun_cnt = r_und_cnt;
`else
    assign underrun_cnt = '0;
`endif

endmodule

// File: tb/tb_dac_dma_rd.sv
// Directed bench for dac_dma_rd: bus responder with programmable latency,
// one-shot strobe generator, assertions at each comparison point.
module tb_dac_dma_rd;

    logic        clk = 1'b0;
    logic        arst;
    logic        cfg_en;
    logic        cfg_loop;
    logic [29:0] cfg_base;
    logic [15:0] cfg_len;
    logic        strobe = 1'b0;
    logic        bus_req;
    logic [29:0] bus_addr;
    logic        bus_gnt;
    logic        bus_rvld = 1'b0;
    logic [31:0] bus_rdat = '0;
    logic [9:0]  dac_ch1;
    logic [9:0]  dac_ch2;
    logic        busy;
    logic        done;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int total = 0;
    int bad = 0;

    dac_dma_rd #(
        .FIFO_DEPTH (8),
        .LEN_W      (16)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .cfg_en       (cfg_en),
        .cfg_loop     (cfg_loop),
        .cfg_base     (cfg_base),
        .cfg_len      (cfg_len),
        .strobe       (strobe),
        .bus_req      (bus_req),
        .bus_addr     (bus_addr),
        .bus_gnt      (bus_gnt),
        .bus_rvld     (bus_rvld),
        .bus_rdat     (bus_rdat),
        .dac_ch1      (dac_ch1),
        .dac_ch2      (dac_ch2),
        .busy         (busy),
        .done         (done),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    // bus responder
    logic [29:0] addr_log[$];
    logic        pend = 1'b0;
    logic [29:0] paddr = '0;
    int          lat = 0;
    int          lat_cnt = 0;

    function automatic logic [31:0] mk(input logic [29:0] a);
        return {6'h2A, ~a[9:0], 6'h15, a[9:0]};
    endfunction

    always @(negedge clk) begin
        bus_rvld = 1'b0;
        if (pend) begin
            if (lat_cnt == 0) begin
                bus_rvld = 1'b1;
                bus_rdat = mk(paddr);
                pend = 1'b0;
            end else begin
                lat_cnt--;
            end
        end else if (bus_req && bus_gnt) begin
            pend = 1'b1;
            paddr = bus_addr;
            lat_cnt = lat;
            addr_log.push_back(bus_addr);
        end
    end

    // one-shot strobe generator
    int os_req = 0;
    int os_ack = 0;

    always @(negedge clk) begin
        if (os_ack != os_req) begin
            strobe = 1'b1;
            os_ack++;
        end else begin
            strobe = 1'b0;
        end
    end

    // event monitors
    int done_cnt = 0;
    int req_cyc = 0;

    always @(negedge clk) begin
        if (done)
            done_cnt++;
        if (bus_req)
            req_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk(tag, 32'(seen), 32'd1);
    endtask

    logic [9:0] e1 [4];
    logic [9:0] e2 [4];
    int n0;
    int d0;
    int rq0;
    logic hit;

    initial begin
        arst = 1'b1;
        cfg_en = 1'b0;
        cfg_loop = 1'b0;
        cfg_base = '0;
        cfg_len = '0;
        bus_gnt = 1'b1;
        e1 = '{10'h100, 10'h101, 10'h102, 10'h103};
        e2 = '{10'h2FF, 10'h2FE, 10'h2FD, 10'h2FC};
        repeat (3) @(posedge clk);
        #1;
        arst = 1'b0;
        @(posedge clk);
        #1;

        // reset state
        chk("rst_req", 32'(bus_req), 32'd0);
        chk("rst_addr", 32'(bus_addr), 32'd0);
        chk("rst_ch1", 32'(dac_ch1), 32'h200);
        chk("rst_ch2", 32'(dac_ch2), 32'h200);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_und", 32'(underrun), 32'd0);
        chk("rst_ucnt", 32'(underrun_cnt), 32'd0);

        // single transfer, zero-wait bus
        cfg_base = 30'h100;
        cfg_len = 16'd4;
        cfg_loop = 1'b0;
        lat = 0;
        n0 = addr_log.size();
        cfg_en = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("t1_nrd", 32'(addr_log.size() - n0), 32'd4);
        chk("t1_a0", 32'(addr_log[n0]), 32'h100);
        chk("t1_a3", 32'(addr_log[n0 + 3]), 32'h103);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_hold", 32'(dac_ch1), 32'h200);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            os_req++;
            @(posedge clk);
            #1;
            chk($sformatf("t1_ch1_%0d", i), 32'(dac_ch1), 32'(e1[i]));
            chk($sformatf("t1_ch2_%0d", i), 32'(dac_ch2), 32'(e2[i]));
        end
        @(posedge clk);
        #1;
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_busy_off", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("t1_done_off", 32'(done), 32'd0);
        chk("t1_done_cnt", 32'(done_cnt), 32'd1);
        chk("t1_und", 32'(underrun), 32'd0);

        // zero length
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        cfg_len = 16'd0;
        rq0 = req_cyc;
        d0 = done_cnt;
        cfg_en = 1'b1;
        @(posedge clk);
        #1;
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("t2_done_off", 32'(done), 32'd0);
        chk("t2_noreq", 32'(req_cyc - rq0), 32'd0);
        chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

        // loop mode; mid-transfer config changes are ignored
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        cfg_base = 30'h100;
        cfg_len = 16'd3;
        cfg_loop = 1'b1;
        n0 = addr_log.size();
        d0 = done_cnt;
        cfg_en = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        cfg_base = 30'h555;
        cfg_len = 16'd2;
        cfg_loop = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("t3_nrd", 32'(addr_log.size() - n0), 32'd8);
        chk("t3_a2", 32'(addr_log[n0 + 2]), 32'h102);
        chk("t3_a3", 32'(addr_log[n0 + 3]), 32'h100);
        chk("t3_a5", 32'(addr_log[n0 + 5]), 32'h102);
        chk("t3_a6", 32'(addr_log[n0 + 6]), 32'h100);
        chk("t3_busy", 32'(busy), 32'd1);
        chk("t3_req_full", 32'(bus_req), 32'd0);
        chk("t3_nodone", 32'(done_cnt - d0), 32'd0);
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        chk("t3_abort_busy", 32'(busy), 32'd0);

        // slow bus, strobes while empty
        cfg_base = 30'h200;
        cfg_len = 16'd2;
        cfg_loop = 1'b0;
        lat = 20;
        n0 = addr_log.size();
        cfg_en = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        os_req += 5;
        repeat (8) @(posedge clk);
        #1;
        chk("t4_und", 32'(underrun), 32'd1);
        chk("t4_hold1", 32'(dac_ch1), 32'h103);
        chk("t4_hold2", 32'(dac_ch2), 32'h2FC);
        chk("t4_busy", 32'(busy), 32'd1);
`ifdef DAC_DMA_UNDERRUN_CNT_EN
        chk("t4_ucnt", 32'(underrun_cnt), 32'd5);
`else
        chk("t4_ucnt", 32'(underrun_cnt), 32'd0);
`endif
        repeat (60) @(posedge clk);
        #1;
        chk("t4_nrd", 32'(addr_log.size() - n0), 32'd2);
        os_req += 2;
        wait_done("t4_done_seen", 20);
        chk("t4_ch1", 32'(dac_ch1), 32'h201);
        chk("t4_ch2", 32'(dac_ch2), 32'h1FE);

        // abort while a read is outstanding
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        cfg_base = 30'h300;
        cfg_len = 16'd4;
        lat = 6;
        n0 = addr_log.size();
        d0 = done_cnt;
        cfg_en = 1'b1;
        hit = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (pend) begin
                hit = 1'b1;
                break;
            end
        end
        chk("t5_issue", 32'(hit), 32'd1);
        chk("t5_und_clr", 32'(underrun), 32'd0);
        cfg_en = 1'b0;
        rq0 = req_cyc;
        repeat (20) @(posedge clk);
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_noreq", 32'(req_cyc - rq0), 32'd0);
        chk("t5_nrd", 32'(addr_log.size() - n0), 32'd1);
        chk("t5_rd_done", 32'(pend), 32'd0);
        chk("t5_nodone", 32'(done_cnt - d0), 32'd0);
        chk("t5_ch1", 32'(dac_ch1), 32'h201);
        chk("t5_empty", 32'(dut.u_fifo.empty), 32'd1);

        // backpressure with address wrap
        cfg_base = 30'h3FFF_FFFE;
        cfg_len = 16'd20;
        lat = 0;
        n0 = addr_log.size();
        cfg_en = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        chk("t6_nrd", 32'(addr_log.size() - n0), 32'd8);
        chk("t6_req", 32'(bus_req), 32'd0);
        chk("t6_a1", 32'(addr_log[n0 + 1]), 32'h3FFF_FFFF);
        chk("t6_a2", 32'(addr_log[n0 + 2]), 32'h0);
        os_req++;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_nrd1", 32'(addr_log.size() - n0), 32'd9);
        chk("t6_ch1", 32'(dac_ch1), 32'h3FE);
        chk("t6_ch2", 32'(dac_ch2), 32'h001);
        chk("t6_und", 32'(underrun), 32'd0);
        cfg_en = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
